// File: rtl/alu_mc.sv
// Multi-cycle RISC-V ALU. Single-cycle ops finish one edge after start; MUL,
// DIVU and REMU iterate one bit per clock over WIDTH edges and then pulse done.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_ans,
  output logic             zero
);

  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;      // MUL: shifted multiplicand; DIV: dividend in, quotient out
  logic [WIDTH-1:0] b_q, b_d;      // MUL: shifted multiplier;   DIV: divisor
  logic [WIDTH-1:0] acc_q, acc_d;  // MUL: partial product;      DIV: partial remainder
  logic             busy_d, done_d, zero_d;
  logic [WIDTH-1:0] ans_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             is_multi;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] run_res;

  assign shamt    = src2[SHW-1:0];
  assign is_multi = alu_control inside {OP_MUL, OP_DIVU, OP_REMU};

  always_comb begin
    sc_res = '0;
    case (alu_control)
      OP_ADD:  sc_res = src1 + src2;
      OP_SUB:  sc_res = src1 - src2;
      OP_AND:  sc_res = src1 & src2;
      OP_OR:   sc_res = src1 | src2;
      OP_XOR:  sc_res = src1 ^ src2;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(src1) < $signed(src2)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, src1 < src2};
      OP_SLL:  sc_res = src1 << shamt;
      OP_SRL:  sc_res = src1 >> shamt;
      OP_SRA:  sc_res = $unsigned($signed(src1) >>> shamt);
      default: sc_res = '0;
    endcase
  end

  // One iteration of each multi-cycle algorithm; a division by zero naturally
  // yields an all-ones quotient and a remainder equal to the dividend.
  assign mul_acc  = acc_q + (b_q[0] ? a_q : '0);
  assign rem_sh   = {acc_q, a_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    busy_d  = busy;
    done_d  = 1'b0;
    ans_d   = alu_ans;
    zero_d  = zero;
    run_res = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_multi) begin
            op_d    = alu_control;
            a_d     = src1;
            b_d     = src2;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            ans_d  = sc_res;
            zero_d = (sc_res == '0);
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          acc_d   = mul_acc;
          a_d     = a_q << 1;
          b_d     = b_q >> 1;
          run_res = mul_acc;
        end else begin
          acc_d   = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
          a_d     = {a_q[WIDTH-2:0], ~rem_diff[WIDTH]};
          run_res = (op_q == OP_DIVU) ? a_d : acc_d;
        end
        if (cnt_q == CW'(1)) begin
          ans_d   = run_res;
          zero_d  = (run_res == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_ans <= '0;
      zero    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      busy    <= busy_d;
      done    <= done_d;
      alu_ans <= ans_d;
      zero    <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: table-driven vectors through a scoreboard,
// plus hand-written sequences for busy, back-to-back and reset-abort cases.
module tb_alu_mc;

  localparam int W = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   alu_control;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         busy;
  logic         done;
  logic [W-1:0] alu_ans;
  logic         zero;

  alu_mc #(.WIDTH(W), .SHW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alu_control (alu_control),
    .src1        (src1),
    .src2        (src2),
    .busy        (busy),
    .done        (done),
    .alu_ans     (alu_ans),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] ans;
    int           issue;
    int           edge_off;
    string        name;
  } exp_t;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ans;
  } vec_t;

  exp_t         sb[$];
  vec_t         vecs[$];
  exp_t         mon_e;
  logic [W-1:0] last_ans;

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk)
    if (!rst && start)
      assert (!$isunknown(alu_control)) else $error("alu_control unknown while start=1");

  // Scoreboard: each done pulse retires the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", W'(done), '0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_ans"}, alu_ans, mon_e.ans);
        check({mon_e.name, "_zero"}, W'(zero), W'(mon_e.ans == '0));
        check({mon_e.name, "_done_edge"}, W'(cyc - mon_e.issue - 1), W'(mon_e.edge_off));
      end
    end
  end

  function automatic void add_vec(string name, logic [3:0] op, logic [W-1:0] a,
                                  logic [W-1:0] b, logic [W-1:0] ans);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.ans = ans;
    vecs.push_back(v);
  endfunction

  // Called at a falling edge; the request is accepted at the next rising edge.
  task automatic drive(string name, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                       logic [W-1:0] exp_ans, bit push);
    exp_t e;
    alu_control = op;
    src1        = a;
    src2        = b;
    start       = 1'b1;
    if (push) begin
      e.ans      = exp_ans;
      e.issue    = cyc;
      e.edge_off = (op inside {OP_MUL, OP_DIVU, OP_REMU}) ? W : 0;
      e.name     = name;
      sb.push_back(e);
    end
  endtask

  task automatic wait_empty(string name);
    for (int i = 0; i < W + 8; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      check({name, "_timeout"}, W'(sb.size()), '0);
      sb.delete();
    end
  endtask

  task automatic run_op(vec_t v);
    drive(v.name, v.op, v.a, v.b, v.ans, 1'b1);
    @(negedge clk);
    start = 1'b0;
    #1;
    wait_empty(v.name);
    @(negedge clk);
    check({v.name, "_done_low"}, W'(done), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; alu_control = '0; src1 = '0; src2 = '0;
    #1;
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_ans", alu_ans, '0);
    check("reset_zero", W'(zero), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    add_vec("add",      OP_ADD,  32'd5,         32'hFFFF_FFFD, 32'd2);
    add_vec("sub_zero", OP_SUB,  32'd9,         32'd9,         32'd0);
    add_vec("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0);
    add_vec("and",      OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    add_vec("or",       OP_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    add_vec("slt",      OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1);
    add_vec("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0);
    add_vec("sltu_lt",  OP_SLTU, 32'd1,         32'hFFFF_FFFF, 32'd1);
    add_vec("sll31",    OP_SLL,  32'd1,         32'd31,        32'h8000_0000);
    add_vec("sll_mask", OP_SLL,  32'd1,         32'h21,        32'd2);
    add_vec("srl",      OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000);
    add_vec("sra_neg",  OP_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000);
    add_vec("sra_pos",  OP_SRA,  32'h4000_0000, 32'd4,         32'h0400_0000);
    add_vec("mul",      OP_MUL,  32'd7,         32'd6,         32'd42);
    add_vec("mul_wrap", OP_MUL,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE);
    add_vec("divu",     OP_DIVU, 32'd100,       32'd7,         32'd14);
    add_vec("remu",     OP_REMU, 32'd100,       32'd7,         32'd2);
    add_vec("divu_0",   OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF);
    add_vec("remu_0",   OP_REMU, 32'd5,         32'd0,         32'd5);
    add_vec("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF);
    add_vec("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h10,        32'hF);
    add_vec("op13",     4'd13,   32'd1234,      32'd5678,      32'd0);
    add_vec("op15",     4'd15,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    add_vec("xor",      OP_XOR,  32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA);

    foreach (vecs[i]) run_op(vecs[i]);
    last_ans = vecs[vecs.size() - 1].ans;

    // A start while busy must be ignored and the old result must stay visible.
    drive("mul_ign", OP_MUL, 32'd7, 32'd6, 32'd42, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("run_busy", W'(busy), W'(1));
    check("run_hold", alu_ans, last_ans);
    repeat (8) @(negedge clk);
    drive("ignored_add", OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", W'(busy), W'(1));
    check("ign_hold", alu_ans, last_ans);
    #1;
    wait_empty("mul_ign");
    @(negedge clk);
    check("mul_ign_done_low", W'(done), '0);

    // A start in the done cycle is accepted; done stays high for the new result.
    drive("remu_b2b", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b1);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < W + 8 && !done; k++) @(negedge clk);
    check("b2b_done_seen", W'(done), W'(1));
    drive("add_b2b", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_held", W'(done), W'(1));
    #1;
    wait_empty("add_b2b");
    @(negedge clk);
    check("add_b2b_done_low", W'(done), '0);

    // Reset in the middle of a division aborts it without a clock edge.
    drive("divu_abort", OP_DIVU, 32'd1000, 32'd3, 32'd333, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_ans", alu_ans, '0);
    check("abort_zero", W'(zero), '0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    begin
      vec_t v;
      v.name = "add_after_rst"; v.op = OP_ADD; v.a = 32'd1; v.b = 32'd1; v.ans = 32'd2;
      run_op(v);
    end
    repeat (W + 8) @(negedge clk);
    check("no_late_done", W'(done), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
